hazard_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32 core. It drives stall, flush and operand-forward selects for the F/D/E/M/W pipeline registers, and resolves:
- load-use hazards;
- taken branch/jump redirects;
- multi-cycle data-memory waits, with a timeout.

It sits beside the datapath, observing register indices and control bits from D, E, M and W, and feeds enables/clears back to every pipeline register.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/forwarding_unit.sv | 18 +
 rtl/hazard_controller.sv | 122 ++++++++++++
 tb/tb_hazard_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM encoding, forward-select constants and helpers for the hazard controller
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

  // M stage is younger than W, so its result takes precedence; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic [4:0] rd_w, input logic we_m,
                                         input logic we_w);
    return (we_m && rd_m != 5'd0 && rd_m == rs) ? FWD_M :
           (we_w && rd_w != 5'd0 && rd_w == rs) ? FWD_W : FWD_RF;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: combinational operand forward selects for both E-stage sources
import hazard_pkg::*;

module forwarding_unit (
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  assign ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward sequencing for the 5-stage core; HAZARD_PERF_EN builds perf counters
import hazard_pkg::*;

module hazard_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallAll,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr,
  output logic [31:0] PerfStall,
  output logic [31:0] PerfFlush,
  output logic [31:0] PerfWait
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       hold, timeout, lw_stall, run;
  logic [1:0] fwd_a, fwd_b;

  forwarding_unit u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (fwd_a),
    .ForwardBE (fwd_b)
  );

  assign lw_stall = ResultSrcE == RES_LOAD && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

  // Next state and freeze decision; a timeout releases the freeze even without MemReadyM
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold      = 1'b0;
    timeout   = 1'b0;
    if (state == RUN) begin
      if (MemReqM && !MemReadyM) begin
        hold      = 1'b1;
        cnt_nxt   = 8'd1;
        state_nxt = MEM_WAIT;
      end
    end else if (MemReadyM) begin
      state_nxt = RUN;
      cnt_nxt   = 8'd0;
    end else if (cnt >= TMO) begin
      timeout   = 1'b1;
      state_nxt = RUN;
      cnt_nxt   = 8'd0;
    end else begin
      hold    = 1'b1;
      cnt_nxt = cnt + 8'd1;
    end
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      cnt    <= 8'd0;
      MemErr <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      MemErr <= MemErr | timeout;
    end
  end

  // While in reset the pipeline drains: flushes high, everything else quiet
  assign run       = rst & ~hold;
  assign StallAll  = rst & hold;
  assign StallF    = run & lw_stall;
  assign StallD    = run & lw_stall;
  assign FlushD    = ~rst | (run & PCSrcE);
  assign FlushE    = ~rst | (run & (PCSrcE | lw_stall));
  assign ForwardAE = rst ? fwd_a : FWD_RF;
  assign ForwardBE = rst ? fwd_b : FWD_RF;

`ifdef HAZARD_PERF_EN
  // Saturating event counters for load-use stalls, branch flushes and memory-wait cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PerfStall <= 32'd0;
      PerfFlush <= 32'd0;
      PerfWait  <= 32'd0;
    end else begin
      PerfStall <= PerfStall + {31'd0, run & lw_stall & ~&PerfStall};
      PerfFlush <= PerfFlush + {31'd0, run & PCSrcE & ~&PerfFlush};
      PerfWait  <= PerfWait + {31'd0, hold & ~&PerfWait};
    end
  end
`else
  assign PerfStall = 32'd0;
  assign PerfFlush = 32'd0;
  assign PerfWait  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed and random checks of hazard_controller against a stall-count reference model
module tb_hazard_controller;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic        StallF, StallD, StallAll, FlushD, FlushE, MemErr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] PerfStall, PerfFlush, PerfWait;

  int tests = 0;
  int fails = 0;

  int          pending;
  bit          m_err;
  int unsigned ps, pf, pw;

  hazard_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .RdM        (RdM),
    .RdW        (RdW),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallAll   (StallAll),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .MemErr     (MemErr),
    .PerfStall  (PerfStall),
    .PerfFlush  (PerfFlush),
    .PerfWait   (PerfWait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk_perf(input string tag);
`ifdef HAZARD_PERF_EN
    chk({tag, ".perf_stall"}, PerfStall, 32'(ps));
    chk({tag, ".perf_flush"}, PerfFlush, 32'(pf));
    chk({tag, ".perf_wait"}, PerfWait, 32'(pw));
`else
    chk({tag, ".perf_stall"}, PerfStall, 32'd0);
    chk({tag, ".perf_flush"}, PerfFlush, 32'd0);
    chk({tag, ".perf_wait"}, PerfWait, 32'd0);
`endif
  endtask

  task automatic model_reset();
    pending = 0;
    m_err   = 1'b0;
    ps = 0;
    pf = 0;
    pw = 0;
  endtask

  // Called just after a rising edge; checks at the falling edge, advances the model at the next rising edge
  task automatic cycle(input string tag);
    bit lw, hold, brk;
    @(negedge clk);
    lw   = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    hold = (pending == 0) ? (MemReqM && !MemReadyM) : (!MemReadyM && pending < TMO);
    brk  = !hold && PCSrcE;
    chk({tag, ".fwd_a"}, 32'(ForwardAE), 32'(fwd(Rs1E)));
    chk({tag, ".fwd_b"}, 32'(ForwardBE), 32'(fwd(Rs2E)));
    chk({tag, ".stall_all"}, 32'(StallAll), 32'(hold));
    chk({tag, ".stall_f"}, 32'(StallF), 32'(!hold && lw));
    chk({tag, ".stall_d"}, 32'(StallD), 32'(!hold && lw));
    chk({tag, ".flush_d"}, 32'(FlushD), 32'(brk));
    chk({tag, ".flush_e"}, 32'(FlushE), 32'(brk || (!hold && lw)));
    chk({tag, ".mem_err"}, 32'(MemErr), 32'(m_err));
    chk_perf(tag);
    @(posedge clk);
    if (pending > 0 && !MemReadyM && pending >= TMO) m_err = 1'b1;
    pending = hold ? pending + 1 : 0;
    if (!hold && lw && ps != 32'hFFFFFFFF) ps++;
    if (brk && pf != 32'hFFFFFFFF) pf++;
    if (hold && pw != 32'hFFFFFFFF) pw++;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".stall_all"}, 32'(StallAll), 32'd0);
    chk({tag, ".stall_f"}, 32'(StallF), 32'd0);
    chk({tag, ".stall_d"}, 32'(StallD), 32'd0);
    chk({tag, ".flush_d"}, 32'(FlushD), 32'd1);
    chk({tag, ".flush_e"}, 32'(FlushE), 32'd1);
    chk({tag, ".fwd_a"}, 32'(ForwardAE), 32'd0);
    chk({tag, ".fwd_b"}, 32'(ForwardBE), 32'd0);
    chk({tag, ".mem_err"}, 32'(MemErr), 32'd0);
    chk({tag, ".perf_stall"}, PerfStall, 32'd0);
    chk({tag, ".perf_flush"}, PerfFlush, 32'd0);
    chk({tag, ".perf_wait"}, PerfWait, 32'd0);
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
  endtask

  initial begin
    int stall_seen;
    rst = 1'b0;
    clear_inputs();
    Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Forwarding priority and x0 suppression
    RdW = 5'd5; RegWriteW = 1'b1;
    cycle("fwd_m");
    chk("fwd_m.const", 32'(ForwardAE), 32'd2);
    RegWriteM = 1'b0;
    cycle("fwd_w");
    chk("fwd_w.const", 32'(ForwardAE), 32'd1);
    RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
    cycle("fwd_x0");
    clear_inputs();

    // Load-use bubble, then branch, then both together
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    cycle("load_use");
    ResultSrcE = 2'b00;
    cycle("load_use_clear");
    PCSrcE = 1'b1;
    cycle("branch");
    ResultSrcE = 2'b01;
    cycle("branch_load");
    clear_inputs();
    cycle("idle");

    // Three-cycle memory wait then ready
    MemReqM = 1'b1;
    stall_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall_seen += int'(StallAll);
      @(posedge clk);
      #1;
      pending = pending + 1;
      pw++;
    end
    chk("mem_wait.len", 32'(stall_seen), 32'd3);
    MemReadyM = 1'b1;
    cycle("mem_ready");
    MemReqM = 1'b0; MemReadyM = 1'b0;
    cycle("mem_idle");

    // Ready in the request cycle: no stall
    MemReqM = 1'b1; MemReadyM = 1'b1;
    cycle("mem_same");
    MemReqM = 1'b0; MemReadyM = 1'b0;

    // Timeout: four stall cycles then release with sticky error
    MemReqM = 1'b1;
    cycle("tmo_req");
    MemReqM = 1'b0;
    for (int i = 0; i < 4; i++) cycle("tmo_wait");
    cycle("tmo_after");
    chk("tmo.err", 32'(MemErr), 32'd1);

    // Asynchronous reset mid-wait
    MemReqM = 1'b1;
    cycle("rst_req");
    cycle("rst_wait");
    Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; PCSrcE = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset("rst_mid");
    model_reset();
    MemReqM = 1'b0; MemReadyM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle("rst_after");

    // Random traffic with small register indices for frequent matches
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3));
      Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3));
      Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3));
      RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      MemReqM    = ($urandom_range(0, 2) == 0);
      MemReadyM  = ($urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
